// File: rtl/debounced_pio_pkg.sv
// Shared definitions for the debounced input PIO: register addresses, edge
// capture modes and CONFIG bit positions.
package debounced_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CFG  = 2'd3;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } edge_mode_e;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_MSB = 1;
  localparam int CFG_INV_BIT  = 2;

  function automatic logic edge_event(input edge_mode_e mode,
                                      input logic       rise,
                                      input logic       fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser, consecutive-stable counter debounce,
// and a one-clock delayed copy of the stable level for edge detection.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic eff_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;
  logic             stb_dly_q, stb_dly_d;

  always_comb begin
    sync1_d   = eff_in;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    stb_d     = stb_q;
    stb_dly_d = stb_q;
    // Any sample agreeing with the stable level restarts the count.
    if (sync2_q == stb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      stb_q     <= 1'b0;
      stb_dly_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      stb_dly_q <= stb_dly_d;
    end
  end

  assign level = stb_q;
  assign rise  = stb_q & ~stb_dly_q;
  assign fall  = ~stb_q & stb_dly_q;

endmodule

// File: rtl/debounced_input_pio.sv
// Avalon-MM slave exposing WIDTH debounced board inputs with sticky edge
// capture, optional inversion and a maskable level interrupt.
module debounced_input_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_raw,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  output logic [WIDTH-1:0] level_out
);

  import debounced_pio_pkg::*;

  // Bus handshake: no waitrequest. A write takes effect on the clock edge where
  // avs_write is high. A read samples register state on the edge where avs_read
  // is high and avs_readdata holds that value from then until the next read;
  // with read and write together the read returns the pre-write value.

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  edge_mode_e       mode_q, mode_d;
  logic             inv_q, inv_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] eff;
  logic [WIDTH-1:0] stb;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rdata;
  logic             unused_wdata;

  // Inverting ahead of the synchroniser makes an INV toggle look like a real
  // input change, so it re-debounces and is captured as an ordinary edge.
  assign eff = in_raw ^ {WIDTH{inv_q}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .eff_in (eff[i]),
      .level  (stb[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
    assign edge_set[i] = edge_event(mode_q, rise[i], fall[i]);
  end

  assign unused_wdata = ^avs_writedata;

  always_comb begin
    mask_d   = mask_q;
    mode_d   = mode_q;
    inv_d    = inv_q;
    edge_clr = '0;
    if (avs_write) begin
      case (avs_address)
        ADDR_MASK: mask_d = avs_writedata[WIDTH-1:0];
        ADDR_EDGE: edge_clr = avs_writedata[WIDTH-1:0];
        ADDR_CFG: begin
          mode_d = edge_mode_e'(avs_writedata[CFG_MODE_MSB:CFG_MODE_LSB]);
          inv_d  = avs_writedata[CFG_INV_BIT];
        end
        default: ;
      endcase
    end
    // Set is ORed in after the clear so a same-cycle event is never lost.
    edge_d = (edge_q & ~edge_clr) | edge_set;
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    rdata = '0;
    case (avs_address)
      ADDR_DATA: rdata[WIDTH-1:0] = stb;
      ADDR_MASK: rdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rdata[WIDTH-1:0] = edge_q;
      ADDR_CFG: begin
        rdata[CFG_MODE_MSB:CFG_MODE_LSB] = mode_q;
        rdata[CFG_INV_BIT]               = inv_q;
      end
      default: ;
    endcase
    readdata_d = avs_read ? rdata : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      mode_q     <= MODE_RISE;
      inv_q      <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      mode_q     <= mode_d;
      inv_q      <= inv_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;
  assign level_out    = stb;

endmodule

// File: tb/tb_debounced_input_pio.sv
// Directed and randomized bench for debounced_input_pio (WIDTH=4,
// DEBOUNCE_CYCLES=4) with a window-based behavioural reference model.
module tb_debounced_input_pio;

  localparam int W  = 4;
  localparam int DB = 4;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_EDGE = 2'd2;
  localparam logic [1:0] A_CFG  = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  in_raw;
  logic [1:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [W-1:0]  level_out;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] hist_q[$];
  logic [W-1:0] m_lvl, m_prev, m_edge, m_mask;
  logic         m_irq;

  debounced_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DB), .CNT_W(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_raw       (in_raw),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .level_out    (level_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  // Driver tasks: all start and end just after a falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d        = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
  endtask

  // Reference model: a level flips once the last DB synchronised samples
  // (each lagging the pin by two clocks) all disagree with it.
  task automatic model_step(input logic [W-1:0] eff);
    logic [W-1:0] nl;
    logic         all_diff;
    int           n;
    hist_q.push_back(eff);
    n  = hist_q.size();
    nl = m_lvl;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (hist_q[n-3-j][b] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) nl[b] = ~m_lvl[b];
    end
    m_irq  = |(m_edge & m_mask);
    m_edge = m_edge | (m_lvl ^ m_prev);
    m_prev = m_lvl;
    m_lvl  = nl;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_raw = 4'hF;
    bus_write(A_MASK, 32'hF);
    tick(10);
    bus_read(A_MASK, d);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL pre_reset_mask: got %0h expected f", d); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    checks++;
    if (level_out !== 4'h0) begin errors++; $display("FAIL reset_level: got %0h expected 0", level_out); end
    checks++;
    if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %0h expected 0", avs_readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %0h expected 0", a, d); end
    end
    tick(1);
    checks++;
    if (level_out !== 4'h0) begin errors++; $display("FAIL reset_level_clk5: got %0h expected 0", level_out); end
    tick(1);
    checks++;
    if (level_out !== 4'hF) begin errors++; $display("FAIL reset_level_clk6: got %0h expected f", level_out); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic        seen;
    in_raw = 4'h0;
    tick(10);
    bus_write(A_EDGE, 32'hF);
    in_raw = 4'h1;
    tick(3);
    in_raw = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | level_out[0];
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch3_level: got %0b expected 0", seen); end
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch3_edge: got %0h expected 0", d); end
    in_raw = 4'h1;
    tick(4);
    in_raw = 4'h0;
    tick(1);
    checks++;
    if (level_out[0] !== 1'b0) begin errors++; $display("FAIL pulse4_clk5: got %0b expected 0", level_out[0]); end
    tick(1);
    checks++;
    if (level_out[0] !== 1'b1) begin errors++; $display("FAIL pulse4_clk6: got %0b expected 1", level_out[0]); end
    tick(10);
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL pulse4_edge: got %0h expected 1", d); end
    bus_write(A_EDGE, 32'hF);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(A_MASK, 32'h2);
    bus_write(A_CFG, 32'h0);
    in_raw      = 4'h2;
    avs_address = A_EDGE;
    avs_read    = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      if (n == 5) begin
        checks++;
        if (level_out[1] !== 1'b0) begin errors++; $display("FAIL irq_level_clk5: got %0b expected 0", level_out[1]); end
      end
      if (n == 6) begin
        checks++;
        if (level_out[1] !== 1'b1) begin errors++; $display("FAIL irq_level_clk6: got %0b expected 1", level_out[1]); end
      end
      if (n == 7) begin
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clk7: got %0b expected 0", irq); end
      end
      if (n == 8) begin
        checks++;
        if (avs_readdata !== 32'h2) begin errors++; $display("FAIL irq_edge_clk7: got %0h expected 2", avs_readdata); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_clk8: got %0b expected 1", irq); end
      end
    end
    avs_read = 1'b0;
    bus_write(A_EDGE, 32'h1);
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_wrong_clear: got %0b expected 1", irq); end
    bus_write(A_EDGE, 32'h2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_same_clk: got %0b expected 1", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %0b expected 0", irq); end
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL irq_edge_cleared: got %0h expected 0", d); end
    in_raw = 4'h0;
    tick(10);
    bus_write(A_EDGE, 32'hF);
  endtask

  task automatic test_modes();
    logic [31:0] d;
    logic [3:0]  exp_r;
    logic [3:0]  exp_f;
    exp_r = 4'b0101;  // indexed by mode: rise, fall, both, none
    exp_f = 4'b0110;
    for (int m = 0; m < 4; m++) begin
      bus_write(A_CFG, 32'(m));
      bus_write(A_EDGE, 32'hF);
      in_raw = 4'h4;
      tick(10);
      bus_read(A_EDGE, d);
      checks++;
      if (d !== (exp_r[m] ? 32'h4 : 32'h0))
        begin errors++; $display("FAIL mode%0d_rise: got %0h expected %0h", m, d, exp_r[m] ? 4 : 0); end
      bus_write(A_EDGE, 32'hF);
      in_raw = 4'h0;
      tick(10);
      bus_read(A_EDGE, d);
      checks++;
      if (d !== (exp_f[m] ? 32'h4 : 32'h0))
        begin errors++; $display("FAIL mode%0d_fall: got %0h expected %0h", m, d, exp_f[m] ? 4 : 0); end
      bus_write(A_EDGE, 32'hF);
    end
    bus_write(A_CFG, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(A_EDGE, 32'hF);
    in_raw = 4'h1;
    tick(6);
    bus_write(A_EDGE, 32'h1);
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL collision_set_wins: got %0h expected 1", d); end
    bus_write(A_EDGE, 32'h1);
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL collision_later_clear: got %0h expected 0", d); end
    in_raw = 4'h0;
    tick(10);
    bus_write(A_EDGE, 32'hF);
  endtask

  task automatic test_invert();
    logic [31:0] d;
    in_raw = 4'h0;
    bus_write(A_EDGE, 32'hF);
    bus_write(A_CFG, 32'h4);
    tick(5);
    checks++;
    if (level_out !== 4'h0) begin errors++; $display("FAIL invert_clk5: got %0h expected 0", level_out); end
    tick(1);
    checks++;
    if (level_out !== 4'hF) begin errors++; $display("FAIL invert_clk6: got %0h expected f", level_out); end
    bus_read(A_DATA, d);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL invert_data: got %0h expected f", d); end
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL invert_edge: got %0h expected f", d); end
    bus_read(A_CFG, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL invert_cfg: got %0h expected 4", d); end
    bus_write(A_CFG, 32'h0);
    tick(10);
    bus_write(A_EDGE, 32'hF);
  endtask

  task automatic test_random();
    logic [W-1:0] nxt;
    logic [31:0]  d;
    in_raw = 4'h0;
    do_reset();
    bus_write(A_MASK, 32'hF);
    bus_write(A_CFG, 32'h2);
    hist_q.delete();
    for (int i = 0; i < 8; i++) hist_q.push_back('0);
    m_lvl  = '0;
    m_prev = '0;
    m_edge = '0;
    m_mask = 4'hF;
    m_irq  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      nxt = in_raw;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 3) == 0) nxt[b] = ~nxt[b];
      in_raw = nxt;
      @(posedge clk);
      model_step(in_raw);
      @(negedge clk);
      checks++;
      if (level_out !== m_lvl)
        begin errors++; $display("FAIL rand_level c=%0d: got %0h expected %0h", c, level_out, m_lvl); end
      checks++;
      if (irq !== m_irq)
        begin errors++; $display("FAIL rand_irq c=%0d: got %0b expected %0b", c, irq, m_irq); end
    end
    bus_read(A_EDGE, d);
    checks++;
    if (d !== 32'(m_edge)) begin errors++; $display("FAIL rand_edge: got %0h expected %0h", d, m_edge); end
  endtask

  initial begin
    reset_n       = 1'b0;
    in_raw        = '0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    @(negedge clk);
    do_reset();
    test_reset();
    test_glitch();
    test_irq();
    test_modes();
    test_collision();
    test_invert();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
